// File: rtl/master_port.sv
// Serial bus master port: latches one device request, arbitrates for the bus and
// shifts address/data out (and read data in) one bit per beat. Optional stall timeout: MASTER_PORT_TIMEOUT_EN.
module master_port #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              in_clk,
  input  logic              reset_n,
  input  logic              dev_req,
  input  logic              dev_write,
  input  logic [ADDR_W-1:0] dev_addr,
  input  logic [DATA_W-1:0] dev_wdata,
  output logic              dev_ready,
  output logic              dev_done,
  output logic [DATA_W-1:0] dev_rdata,
  output logic              dev_err,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic              ser_out_valid_ready,
  input  logic              ser_in_valid_ready,
  output logic              out_addr,
  output logic              out_write,
  output logic              ser_wdata,
  input  logic              ser_rdata
);

  // state     | meaning
  // IDLE      | ready for a device request
  // ARB       | request latched, waiting for bus grant
  // ADDR      | sending low address bits (ADDR_W-DATA_W of them)
  // ADDR_DATA | write: sending high address bits with write data bits
  // ADDR_RD   | read: sending high address bits
  // RDATA     | read: receiving DATA_W data bits
  // DONE      | one-cycle completion pulse, bus released
  localparam int CNT_W = $clog2(ADDR_W + 1);
  localparam logic [CNT_W-1:0] LO_LAST   = CNT_W'(ADDR_W - DATA_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, ARB, ADDR, ADDR_DATA, ADDR_RD, RDATA, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                write_q, write_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                in_xfer, serial_ph, addr_ph, beat;
`ifdef MASTER_PORT_TIMEOUT_EN
  logic [7:0]          stall_q, stall_d;
  logic                err_q, err_d;
`endif

  assign in_xfer   = (state_q != IDLE) && (state_q != DONE);
  assign addr_ph   = (state_q == ADDR) || (state_q == ADDR_DATA) || (state_q == ADDR_RD);
  assign serial_ph = addr_ph || (state_q == RDATA);
  assign beat      = ser_out_valid_ready && ser_in_valid_ready;

  assign dev_ready           = (state_q == IDLE);
  assign dev_done            = (state_q == DONE);
  assign dev_rdata           = dev_done ? rdata_q : '0;
  assign bus_req             = in_xfer;
  assign ser_out_valid_ready = serial_ph && bus_grant;
  assign out_addr            = addr_ph && addr_q[0];
  assign out_write           = serial_ph && write_q;
  assign ser_wdata           = (state_q == ADDR_DATA) && wdata_q[0];
`ifdef MASTER_PORT_TIMEOUT_EN
  assign dev_err             = dev_done && err_q;
`else
  assign dev_err             = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    write_d = write_q;
    cnt_d   = cnt_q;
`ifdef MASTER_PORT_TIMEOUT_EN
    stall_d = stall_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: if (dev_req) begin
        addr_d  = dev_addr;
        wdata_d = dev_wdata;
        write_d = dev_write;
        rdata_d = '0;
        state_d = ARB;
      end
      ARB: if (bus_grant) state_d = ADDR;
      ADDR: if (beat) begin
        addr_d = addr_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LO_LAST) state_d = write_q ? ADDR_DATA : ADDR_RD;
      end
      ADDR_DATA: if (beat) begin
        addr_d  = addr_q >> 1;
        wdata_d = wdata_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == DATA_LAST) state_d = DONE;
      end
      ADDR_RD: if (beat) begin
        addr_d = addr_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == DATA_LAST) state_d = RDATA;
      end
      // first received bit ends up in rdata_q[0] after DATA_W shifts
      RDATA: if (beat) begin
        rdata_d = {ser_rdata, rdata_q[DATA_W-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == DATA_LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef MASTER_PORT_TIMEOUT_EN
    if (state_q == IDLE) err_d = 1'b0;
    if (!in_xfer || beat || (state_d != state_q)) begin
      stall_d = '0;
    end else if (stall_q == 8'd254) begin
      stall_d = '0;
      err_d   = 1'b1;
      rdata_d = '0;
      state_d = DONE;
    end else begin
      stall_d = stall_q + 8'd1;
    end
`endif
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
`ifdef MASTER_PORT_TIMEOUT_EN
      stall_q <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      write_q <= write_d;
      cnt_q   <= cnt_d;
`ifdef MASTER_PORT_TIMEOUT_EN
      stall_q <= stall_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule
